// File: rtl/rename_stage.sv
// Register rename stage: speculative/committed RATs and a circular free list with wrap-bit pointers.
// Optional `RENAME_PERF_CNT_EN adds o_fl_stall_cnt, a count of cycles stalled on free-list exhaustion.
module rename_stage #(
   parameter int unsigned WIDTH     = 2,
   parameter int unsigned NUM_AREGS = 32,
   parameter int unsigned NUM_PREGS = 64,
   parameter int unsigned PREG_W    = $clog2(NUM_PREGS)
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [WIDTH-1:0]        i_valid,
   input  logic [WIDTH*5-1:0]      i_rd,
   input  logic [WIDTH*5-1:0]      i_rs1,
   input  logic [WIDTH*5-1:0]      i_rs2,
   input  logic [WIDTH-1:0]        i_rd_wen,
   output logic                    o_dequeue,
   input  logic                    i_stall,
   input  logic                    i_flush,
   output logic [WIDTH-1:0]        o_valid,
   output logic [WIDTH*PREG_W-1:0] o_prd,
   output logic [WIDTH*PREG_W-1:0] o_prs1,
   output logic [WIDTH*PREG_W-1:0] o_prs2,
   output logic [WIDTH*PREG_W-1:0] o_old_prd,
`ifdef RENAME_PERF_CNT_EN
   output logic [31:0]             o_fl_stall_cnt,
`endif
   input  logic [WIDTH-1:0]        i_cmt_valid,
   input  logic [WIDTH*5-1:0]      i_cmt_rd,
   input  logic [WIDTH*PREG_W-1:0] i_cmt_prd,
   input  logic [WIDTH*PREG_W-1:0] i_cmt_old_prd
);
   localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
   localparam int FL_IDX_W = $clog2(FL_DEPTH);
   localparam int PTR_W    = FL_IDX_W + 1;

   logic [PREG_W-1:0] spec_rat_q [NUM_AREGS];
   logic [PREG_W-1:0] spec_rat_d [NUM_AREGS];
   logic [PREG_W-1:0] cmt_rat_q [NUM_AREGS];
   logic [PREG_W-1:0] cmt_rat_d [NUM_AREGS];
   logic [PREG_W-1:0] fl_q [FL_DEPTH];
   logic [PREG_W-1:0] fl_d [FL_DEPTH];
   logic [PTR_W-1:0]  head_q, head_d, cmt_head_q, cmt_head_d, tail_q, tail_d;
   logic [WIDTH-1:0]  valid_q, valid_d;
   logic [WIDTH*PREG_W-1:0] prd_q, prd_d, prs1_q, prs1_d, prs2_q, prs2_d, old_prd_q, old_prd_d;

   logic [4:0]        slot_rd [WIDTH];
   logic [4:0]        slot_rs1 [WIDTH];
   logic [4:0]        slot_rs2 [WIDTH];
   logic [WIDTH-1:0]  wen;
   logic [PTR_W-1:0]  n_wen, free_cnt, free_cnt_d, alloc_cnt, alloc_ptr;
   logic [PREG_W-1:0] new_prd [WIDTH];
   logic [PREG_W-1:0] map_rs1 [WIDTH];
   logic [PREG_W-1:0] map_rs2 [WIDTH];
   logic [PREG_W-1:0] map_old [WIDTH];
   logic              fl_ok;

   always_comb begin
      wen   = '0;
      n_wen = '0;
      for (int i = 0; i < WIDTH; i++) begin
         slot_rd[i]  = i_rd[i*5 +: 5];
         slot_rs1[i] = i_rs1[i*5 +: 5];
         slot_rs2[i] = i_rs2[i*5 +: 5];
         wen[i]      = i_valid[i] & i_rd_wen[i] & (slot_rd[i] != 5'd0);
         n_wen       = n_wen + PTR_W'(wen[i]);
      end
   end

   assign free_cnt  = tail_q - head_q;
   assign fl_ok     = free_cnt >= n_wen;
   assign o_dequeue = i_rst_n & ~i_stall & ~i_flush & (|i_valid) & fl_ok;

   // Older slots in the group override the RAT lookup of younger slots (intra-group bypass).
   always_comb begin
      alloc_cnt = '0;
      alloc_ptr = '0;
      for (int i = 0; i < WIDTH; i++) begin
         alloc_ptr  = head_q + alloc_cnt;
         new_prd[i] = wen[i] ? fl_q[alloc_ptr[FL_IDX_W-1:0]] : '0;
         alloc_cnt  = alloc_cnt + PTR_W'(wen[i]);
         map_rs1[i] = (slot_rs1[i] == 5'd0) ? '0 : spec_rat_q[slot_rs1[i]];
         map_rs2[i] = (slot_rs2[i] == 5'd0) ? '0 : spec_rat_q[slot_rs2[i]];
         map_old[i] = spec_rat_q[slot_rd[i]];
         for (int j = 0; j < WIDTH; j++) begin
            if (j < i && wen[j]) begin
               if (slot_rd[j] == slot_rs1[i]) map_rs1[i] = new_prd[j];
               if (slot_rd[j] == slot_rs2[i]) map_rs2[i] = new_prd[j];
               if (slot_rd[j] == slot_rd[i])  map_old[i] = new_prd[j];
            end
         end
         if (!wen[i]) map_old[i] = '0;
      end
   end

   // Commit: freed registers are appended at the tail and only visible to allocation next cycle.
   always_comb begin
      cmt_rat_d  = cmt_rat_q;
      fl_d       = fl_q;
      tail_d     = tail_q;
      cmt_head_d = cmt_head_q;
      for (int i = 0; i < WIDTH; i++) begin
         if (i_cmt_valid[i]) begin
            if (i_cmt_rd[i*5 +: 5] != 5'd0) begin
               cmt_rat_d[i_cmt_rd[i*5 +: 5]] = i_cmt_prd[i*PREG_W +: PREG_W];
            end
            fl_d[tail_d[FL_IDX_W-1:0]] = i_cmt_old_prd[i*PREG_W +: PREG_W];
            tail_d     = tail_d + 1'b1;
            cmt_head_d = cmt_head_d + 1'b1;
         end
      end
   end

   always_comb begin
      spec_rat_d = spec_rat_q;
      head_d     = head_q;
      valid_d    = valid_q;
      prd_d      = prd_q;
      prs1_d     = prs1_q;
      prs2_d     = prs2_q;
      old_prd_d  = old_prd_q;
      if (i_flush) begin
         spec_rat_d = cmt_rat_d;
         head_d     = cmt_head_d;
         valid_d    = '0;
      end else if (o_dequeue) begin
         head_d  = head_q + n_wen;
         valid_d = i_valid;
         for (int i = 0; i < WIDTH; i++) begin
            if (wen[i]) spec_rat_d[slot_rd[i]] = new_prd[i];
            prd_d[i*PREG_W +: PREG_W]     = new_prd[i];
            prs1_d[i*PREG_W +: PREG_W]    = i_valid[i] ? map_rs1[i] : '0;
            prs2_d[i*PREG_W +: PREG_W]    = i_valid[i] ? map_rs2[i] : '0;
            old_prd_d[i*PREG_W +: PREG_W] = map_old[i];
         end
      end else if (!i_stall) begin
         valid_d = '0;
      end
   end

   assign free_cnt_d = tail_d - head_d;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int a = 0; a < NUM_AREGS; a++) begin
            spec_rat_q[a] <= PREG_W'(a);
            cmt_rat_q[a]  <= PREG_W'(a);
         end
         for (int k = 0; k < FL_DEPTH; k++) fl_q[k] <= PREG_W'(NUM_AREGS + k);
         head_q     <= '0;
         cmt_head_q <= '0;
         tail_q     <= PTR_W'(FL_DEPTH);
         valid_q    <= '0;
         prd_q      <= '0;
         prs1_q     <= '0;
         prs2_q     <= '0;
         old_prd_q  <= '0;
      end else begin
         spec_rat_q <= spec_rat_d;
         cmt_rat_q  <= cmt_rat_d;
         fl_q       <= fl_d;
         head_q     <= head_d;
         cmt_head_q <= cmt_head_d;
         tail_q     <= tail_d;
         valid_q    <= valid_d;
         prd_q      <= prd_d;
         prs1_q     <= prs1_d;
         prs2_q     <= prs2_d;
         old_prd_q  <= old_prd_d;
      end
   end

   assign o_valid   = valid_q;
   assign o_prd     = prd_q;
   assign o_prs1    = prs1_q;
   assign o_prs2    = prs2_q;
   assign o_old_prd = old_prd_q;

`ifdef RENAME_PERF_CNT_EN
   logic [31:0] fl_stall_cnt_q, fl_stall_cnt_d;

   always_comb begin
      fl_stall_cnt_d = fl_stall_cnt_q;
      if ((|i_valid) && !i_stall && !i_flush && !fl_ok && (fl_stall_cnt_q != 32'hFFFF_FFFF)) begin
         fl_stall_cnt_d = fl_stall_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) fl_stall_cnt_q <= '0;
      else          fl_stall_cnt_q <= fl_stall_cnt_d;
   end

   assign o_fl_stall_cnt = fl_stall_cnt_q;
`endif

   // Committing more registers than are in flight would overfill the free list.
   assert property (@(posedge i_clk) disable iff (!i_rst_n) free_cnt_d <= PTR_W'(FL_DEPTH));

endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed scenarios plus random traffic against a
// queue-based reference model (free list, in-flight list, two RAT arrays).
module tb_rename_stage;
   localparam int W  = 2;
   localparam int PW = 6;

   logic            i_clk = 1'b0;
   logic            i_rst_n;
   logic [W-1:0]    i_valid, i_rd_wen, i_cmt_valid, o_valid;
   logic [W*5-1:0]  i_rd, i_rs1, i_rs2, i_cmt_rd;
   logic            i_stall, i_flush, o_dequeue;
   logic [W*PW-1:0] o_prd, o_prs1, o_prs2, o_old_prd, i_cmt_prd, i_cmt_old_prd;
`ifdef RENAME_PERF_CNT_EN
   logic [31:0]     o_fl_stall_cnt;
   int unsigned     e_cnt;
`endif

   rename_stage dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_valid       (i_valid),
      .i_rd          (i_rd),
      .i_rs1         (i_rs1),
      .i_rs2         (i_rs2),
      .i_rd_wen      (i_rd_wen),
      .o_dequeue     (o_dequeue),
      .i_stall       (i_stall),
      .i_flush       (i_flush),
      .o_valid       (o_valid),
      .o_prd         (o_prd),
      .o_prs1        (o_prs1),
      .o_prs2        (o_prs2),
      .o_old_prd     (o_old_prd),
`ifdef RENAME_PERF_CNT_EN
      .o_fl_stall_cnt(o_fl_stall_cnt),
`endif
      .i_cmt_valid   (i_cmt_valid),
      .i_cmt_rd      (i_cmt_rd),
      .i_cmt_prd     (i_cmt_prd),
      .i_cmt_old_prd (i_cmt_old_prd)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {int rd; int prd; int old;} ent_t;

   int       checks = 0;
   int       errors = 0;
   int       rat [32];
   int       crat [32];
   int       fl [$];
   ent_t     inflight [$];
   bit [1:0] e_valid;
   int       e_prd [W];
   int       e_prs1 [W];
   int       e_prs2 [W];
   int       e_old [W];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int a = 0; a < 32; a++) begin
         rat[a]  = a;
         crat[a] = a;
      end
      fl.delete();
      for (int k = 32; k < 64; k++) fl.push_back(k);
      inflight.delete();
      e_valid = '0;
      for (int s = 0; s < W; s++) begin
         e_prd[s] = 0; e_prs1[s] = 0; e_prs2[s] = 0; e_old[s] = 0;
      end
`ifdef RENAME_PERF_CNT_EN
      e_cnt = 0;
`endif
   endtask

   task automatic idle();
      i_valid = '0; i_rd_wen = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
      i_stall = 1'b0; i_flush = 1'b0;
      i_cmt_valid = '0; i_cmt_rd = '0; i_cmt_prd = '0; i_cmt_old_prd = '0;
   endtask

   task automatic set_slot(input int s, input int rd, input int rs1, input int rs2, input bit wen);
      i_valid[s]        = 1'b1;
      i_rd_wen[s]       = wen;
      i_rd[s*5 +: 5]    = 5'(rd);
      i_rs1[s*5 +: 5]   = 5'(rs1);
      i_rs2[s*5 +: 5]   = 5'(rs2);
   endtask

   // Commit the n oldest in-flight allocations, in program order.
   task automatic set_commit(input int n);
      for (int k = 0; k < n; k++) begin
         i_cmt_valid[k]            = 1'b1;
         i_cmt_rd[k*5 +: 5]        = 5'(inflight[k].rd);
         i_cmt_prd[k*PW +: PW]     = PW'(inflight[k].prd);
         i_cmt_old_prd[k*PW +: PW] = PW'(inflight[k].old);
      end
   endtask

   function automatic bit slot_wen(input int s);
      return i_valid[s] && i_rd_wen[s] && (i_rd[s*5 +: 5] != 5'd0);
   endfunction

   // One clock: check registered outputs and o_dequeue at negedge, then advance the model.
   task automatic cycle();
      int   nw, rd, r1, r2;
      bit   acc;
      int   work [32];
      ent_t newents [$];
      @(negedge i_clk);
      check_eq("valid", o_valid, e_valid);
      for (int s = 0; s < W; s++) begin
         if (e_valid[s]) begin
            check_eq($sformatf("prd%0d", s), o_prd[s*PW +: PW], e_prd[s]);
            check_eq($sformatf("prs1_%0d", s), o_prs1[s*PW +: PW], e_prs1[s]);
            check_eq($sformatf("prs2_%0d", s), o_prs2[s*PW +: PW], e_prs2[s]);
            check_eq($sformatf("old%0d", s), o_old_prd[s*PW +: PW], e_old[s]);
         end
      end
      nw = 0;
      for (int s = 0; s < W; s++) if (slot_wen(s)) nw++;
      acc = !i_stall && !i_flush && (i_valid != '0) && (fl.size() >= nw);
      check_eq("dequeue", o_dequeue, acc);
`ifdef RENAME_PERF_CNT_EN
      check_eq("stall_cnt", o_fl_stall_cnt, e_cnt);
      if ((i_valid != '0) && !i_stall && !i_flush && (fl.size() < nw)) e_cnt++;
`endif
      work = rat;
      if (acc) begin
         for (int s = 0; s < W; s++) begin
            if (i_valid[s]) begin
               rd = int'(i_rd[s*5 +: 5]);
               r1 = int'(i_rs1[s*5 +: 5]);
               r2 = int'(i_rs2[s*5 +: 5]);
               e_prs1[s] = (r1 == 0) ? 0 : work[r1];
               e_prs2[s] = (r2 == 0) ? 0 : work[r2];
               if (slot_wen(s)) begin
                  e_old[s] = work[rd];
                  e_prd[s] = fl.pop_front();
                  work[rd] = e_prd[s];
                  newents.push_back('{rd, e_prd[s], e_old[s]});
               end else begin
                  e_old[s] = 0;
                  e_prd[s] = 0;
               end
            end
         end
         e_valid = i_valid;
         rat     = work;
      end else if (!i_stall || i_flush) begin
         e_valid = '0;
      end
      for (int s = 0; s < W; s++) begin
         if (i_cmt_valid[s]) begin
            void'(inflight.pop_front());
            crat[int'(i_cmt_rd[s*5 +: 5])] = int'(i_cmt_prd[s*PW +: PW]);
            fl.push_back(int'(i_cmt_old_prd[s*PW +: PW]));
         end
      end
      foreach (newents[k]) inflight.push_back(newents[k]);
      if (i_flush) begin
         rat = crat;
         for (int k = inflight.size() - 1; k >= 0; k--) fl.push_front(inflight[k].prd);
         inflight.delete();
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      i_rst_n = 1'b0;
      set_slot(0, 1, 0, 0, 1'b1);
      @(posedge i_clk); #1;
      check_eq("rst_dequeue", o_dequeue, 0);
      @(posedge i_clk); #1;
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_prd", o_prd, 0);
      check_eq("rst_prs1", o_prs1, 0);
      check_eq("rst_old", o_old_prd, 0);
      i_rst_n = 1'b1;
      idle();
      model_reset();
   endtask

   function automatic int rnd_reg();
      return ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 8));
   endfunction

   initial begin
      int n;
      i_rst_n = 1'b0;
      idle();
      model_reset();

      // Single writer after reset.
      do_reset();
      set_slot(0, 5, 1, 2, 1'b1);
      cycle();
      check_eq("t1_valid", o_valid, 2'b01);
      check_eq("t1_prd", o_prd[PW-1:0], 32);
      check_eq("t1_prs1", o_prs1[PW-1:0], 1);
      check_eq("t1_prs2", o_prs2[PW-1:0], 2);
      check_eq("t1_old", o_old_prd[PW-1:0], 5);

      // Intra-group bypass on the same rd.
      do_reset();
      set_slot(0, 3, 0, 0, 1'b1);
      set_slot(1, 3, 3, 0, 1'b1);
      cycle();
      check_eq("t2_prd0", o_prd[PW-1:0], 32);
      check_eq("t2_old0", o_old_prd[PW-1:0], 3);
      check_eq("t2_prs1_1", o_prs1[2*PW-1:PW], 32);
      check_eq("t2_prd1", o_prd[2*PW-1:PW], 33);
      check_eq("t2_old1", o_old_prd[2*PW-1:PW], 32);
      idle();
      set_slot(0, 0, 3, 0, 1'b0);
      cycle();
      check_eq("t2_rat_x3", o_prs1[PW-1:0], 33);

      // Exhaustion, x0 writer still accepted, then a commit refills the list.
      do_reset();
      for (int g = 0; g < 16; g++) begin
         idle();
         set_slot(0, (g == 0) ? 5 : (g % 30) + 1, 0, 0, 1'b1);
         set_slot(1, ((g + 7) % 31) + 1, 0, 0, 1'b1);
         cycle();
      end
      idle();
      set_slot(0, 1, 0, 0, 1'b1);
      cycle();
      check_eq("t3_exh_valid", o_valid, 0);
      idle();
      set_slot(0, 0, 4, 0, 1'b1);
      cycle();
      check_eq("t3_x0_valid", o_valid, 2'b01);
      check_eq("t3_x0_prd", o_prd[PW-1:0], 0);
      idle();
      set_slot(0, 1, 0, 0, 1'b1);
      set_commit(1);
      cycle();
      check_eq("t3_precommit_valid", o_valid, 0);
      idle();
      set_slot(0, 6, 0, 0, 1'b1);
      cycle();
      check_eq("t3_refill_prd", o_prd[PW-1:0], 5);

      // Flush discards uncommitted allocations.
      do_reset();
      set_slot(0, 5, 0, 0, 1'b1);
      set_slot(1, 6, 0, 0, 1'b1);
      cycle();
      idle();
      set_slot(0, 7, 0, 0, 1'b1);
      cycle();
      idle();
      i_flush = 1'b1;
      cycle();
      idle();
      set_slot(0, 5, 5, 0, 1'b1);
      cycle();
      check_eq("t4_prs1", o_prs1[PW-1:0], 5);
      check_eq("t4_prd", o_prd[PW-1:0], 32);
      check_eq("t4_old", o_old_prd[PW-1:0], 5);

      // Flush in the same cycle as a commit keeps that commit.
      do_reset();
      for (int g = 0; g < 4; g++) begin
         idle();
         set_slot(0, 2 * g + 1, 0, 0, 1'b1);
         set_slot(1, 2 * g + 2, 0, 0, 1'b1);
         cycle();
      end
      idle();
      set_slot(0, 9, 0, 0, 1'b1);
      cycle();
      for (int g = 0; g < 4; g++) begin
         idle();
         set_commit(2);
         cycle();
      end
      idle();
      set_commit(1);
      i_flush = 1'b1;
      cycle();
      idle();
      set_slot(0, 0, 9, 0, 1'b0);
      cycle();
      check_eq("t5_x9", o_prs1[PW-1:0], 40);

      // Dispatch stall holds outputs and allocation.
      do_reset();
      set_slot(0, 5, 0, 0, 1'b1);
      cycle();
      for (int k = 0; k < 3; k++) begin
         idle();
         set_slot(0, 6, 0, 0, 1'b1);
         i_stall = 1'b1;
         cycle();
         check_eq("t6_hold_prd", o_prd[PW-1:0], 32);
      end
      idle();
      set_slot(0, 6, 0, 0, 1'b1);
      cycle();
      check_eq("t6_after_prd", o_prd[PW-1:0], 33);

      // Random traffic.
      do_reset();
      for (int c = 0; c < 800; c++) begin
         idle();
         n = int'($urandom_range(0, 2));
         for (int s = 0; s < n; s++) set_slot(s, rnd_reg(), rnd_reg(), rnd_reg(),
                                              $urandom_range(0, 3) != 0);
         i_stall = ($urandom_range(0, 3) == 0);
         i_flush = ($urandom_range(0, 24) == 0);
         n = int'($urandom_range(0, 2));
         if (n > inflight.size()) n = inflight.size();
         if ($urandom_range(0, 2) == 0) set_commit(n);
         cycle();
      end
      idle();
      cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
